// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
//   state_t           : arbiter FSM states
//   REQ_IF / REQ_D    : requester ids, also the arbiter request/grant bit positions
//   MEM_DEPTH_DEFAULT : number of implemented memory words
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;
   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D = 1'b1;
   localparam int MEM_DEPTH_DEFAULT = 101;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter with a last-winner pointer
//   clk, rst : clock, synchronous active-high reset (pointer -> REQ_D)
//   req      : request bits indexed by requester id
//   en       : pointer update enable, asserted when a grant is taken
//   gnt      : one-hot combinational grant
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);
   logic ptr;
   // On a tie the requester that did not win last time gets the grant.
   assign gnt[REQ_IF] = req[REQ_IF] & (~req[REQ_D] | ptr);
   assign gnt[REQ_D] = req[REQ_D] & (~req[REQ_IF] | ~ptr);
   always_ff @(posedge clk)
      if (rst) ptr <= REQ_D;
      else if (en) ptr <= gnt[REQ_D];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port memory between instruction fetch and data ports
//   clk, rst                    : clock, synchronous active-high reset
//   if_req/if_addr/if_gnt       : IF read request, address, accept pulse
//   if_rvalid/if_rdata          : IF read response
//   d_req/d_we/d_addr/d_wdata   : D load/store request
//   d_gnt/d_rvalid/d_wack/d_rdata : D accept pulse and responses
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata : memory interface
//   err/err_addr                : out-of-range pulse and last offending address
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic              d_wack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   state_t state, state_n;
   logic [1:0] req, gnt;
   logic [ADDR_W-1:0] sel_addr, addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic sel_we, we_q, id_q, oob;
   // Requests are only visible to the arbiter when a grant may be issued.
   assign req = {d_req, if_req} & {2{state == IDLE && !rst}};
   rr_arbiter2 u_arb (.clk(clk), .rst(rst), .req(req), .en(|req), .gnt(gnt));
   assign if_gnt = gnt[REQ_IF];
   assign d_gnt = gnt[REQ_D];
   assign sel_addr = gnt[REQ_D] ? d_addr : if_addr;
   assign sel_we = gnt[REQ_D] & d_we;
   assign oob = {1'b0, sel_addr} >= DEPTH;
   assign mem_read = state == RD;
   assign mem_write = state == WR;
   assign mem_addr = addr_q;
   assign mem_wdata = wdata_q;
   // Every access state lasts one cycle, so only IDLE has a choice to make.
   always_comb begin
      state_n = IDLE;
      if (state == IDLE && |req) state_n = oob ? ERR : sel_we ? WR : RD;
   end
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_ff @(posedge clk)
      if (rst) begin
         addr_q <= '0;
         wdata_q <= '0;
         we_q <= 1'b0;
         id_q <= REQ_IF;
         if_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         d_wack <= 1'b0;
         err <= 1'b0;
         if_rdata <= '0;
         d_rdata <= '0;
         err_addr <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         d_wack <= 1'b0;
         err <= 1'b0;
         if (|req) begin
            addr_q <= sel_addr;
            we_q <= sel_we;
            id_q <= gnt[REQ_D];
            if (sel_we) wdata_q <= d_wdata;
         end
         // A rejected read still completes, returning zero.
         if ((state == RD || state == ERR) && !we_q) begin
            if (id_q == REQ_IF) begin
               if_rvalid <= 1'b1;
               if_rdata <= state == RD ? mem_rdata : '0;
            end else begin
               d_rvalid <= 1'b1;
               d_rdata <= state == RD ? mem_rdata : '0;
            end
         end
         if (state == WR || (state == ERR && we_q)) d_wack <= 1'b1;
         if (state == ERR) begin
            err <= 1'b1;
            err_addr <= addr_q;
         end
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a negedge memory model
module tb_mem_port_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic if_gnt, if_rvalid, d_gnt, d_rvalid, d_wack, mem_read, mem_write, err;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, err_addr;
   logic [15:0] mem_rdata = '0;
   logic [15:0] mem [0:100];
   int passed = 0, total = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_wack(d_wack), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .err(err), .err_addr(err_addr)
   );

   always @(negedge clk) begin
      if (mem_write && mem_addr < 16'd101) mem[mem_addr] <= mem_wdata;
      if (mem_read) mem_rdata <= mem_addr < 16'd101 ? mem[mem_addr] : 16'h0000;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 101; i++) mem[i] = 16'h0000;
      mem[3] = 16'h0D00;
      tick;
      tick;
      chk("rst_strobes", {if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_rvalid, d_wack, err}, 0);
      chk("rst_regs", {mem_addr, mem_wdata}, 0);
      chk("rst_data", {if_rdata, d_rdata}, 0);
      chk("rst_err_addr", err_addr, 0);
      if_req = 1'b1;
      if_addr = 16'd3;
      #1 chk("rst_no_grant", if_gnt, 0);
      rst = 1'b0;
      #1 chk("if_gnt_T", {if_gnt, d_gnt, mem_read}, 3'b100);
      tick;
      if_req = 1'b0;
      #1 chk("if_rd_T1", {mem_read, mem_write, if_rvalid}, 3'b100);
      chk("if_addr_T1", mem_addr, 3);
      tick;
      chk("if_rvalid_T2", {if_rvalid, mem_read}, 2'b10);
      chk("if_rdata_T2", if_rdata, 16'h0D00);
      tick;
      chk("if_rvalid_pulse", if_rvalid, 0);
      chk("if_rdata_hold", if_rdata, 16'h0D00);
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 16'd12;
      d_wdata = 16'h1234;
      #1 chk("st_gnt", {if_gnt, d_gnt}, 2'b01);
      tick;
      d_req = 1'b0;
      #1 chk("st_strobe", {mem_read, mem_write, d_wack}, 3'b010);
      chk("st_addr_data", {mem_addr, mem_wdata}, {16'd12, 16'h1234});
      tick;
      chk("st_wack", {d_wack, mem_write}, 2'b10);
      d_req = 1'b1;
      d_we = 1'b0;
      #1 chk("ld_gnt_same_cycle", d_gnt, 1);
      tick;
      d_req = 1'b0;
      #1 chk("ld_strobe", {mem_read, mem_write, d_rvalid}, 3'b100);
      tick;
      chk("ld_rvalid", {d_rvalid, d_wack}, 2'b10);
      chk("ld_rdata", d_rdata, 16'h1234);
      if_req = 1'b1;
      if_addr = 16'd3;
      d_req = 1'b1;
      d_addr = 16'd12;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_gnt%0d", i), {if_gnt, d_gnt}, i % 2 == 0 ? 2'b10 : 2'b01);
         tick;
         chk($sformatf("rr_busy%0d", i), {if_gnt, d_gnt, mem_read}, 3'b001);
         tick;
         chk($sformatf("rr_resp%0d", i), {if_rvalid, d_rvalid}, i % 2 == 0 ? 2'b10 : 2'b01);
      end
      if_req = 1'b0;
      d_req = 1'b0;
      tick;
      chk("rr_idle", {if_gnt, d_gnt, mem_read, if_rvalid, d_rvalid}, 0);
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 16'd150;
      #1 chk("oob_gnt", d_gnt, 1);
      tick;
      d_req = 1'b0;
      #1 chk("oob_no_strobe", {mem_read, mem_write, err}, 0);
      tick;
      chk("oob_err", {err, d_rvalid, d_wack}, 3'b110);
      chk("oob_err_addr", err_addr, 16'd150);
      chk("oob_rdata", d_rdata, 0);
      tick;
      chk("oob_err_pulse", {err, d_rvalid}, 0);
      chk("oob_err_addr_hold", err_addr, 16'd150);
      if_req = 1'b1;
      if_addr = 16'd3;
      #1 chk("abort_gnt", if_gnt, 1);
      tick;
      if_req = 1'b0;
      #1 chk("abort_rd", mem_read, 1);
      rst = 1'b1;
      tick;
      chk("abort_outputs", {if_gnt, d_gnt, mem_read, mem_write, if_rvalid, d_rvalid, d_wack, err}, 0);
      chk("abort_regs", {mem_addr, mem_wdata, if_rdata, err_addr}, 0);
      rst = 1'b0;
      if_req = 1'b1;
      #1 chk("reissue_gnt", if_gnt, 1);
      tick;
      if_req = 1'b0;
      #1 chk("reissue_rd", {mem_read, if_rvalid}, 2'b10);
      tick;
      chk("reissue_rvalid", if_rvalid, 1);
      chk("reissue_rdata", if_rdata, 16'h0D00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
